// File: rtl/cnt_event_logger_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnt_event_logger_if : counter-monitor input and event-FIFO bus       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface cnt_event_logger_if;
  logic        data_valid;
  logic [5:0]  cnt;
  logic        rd_en;
  logic [15:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic        wrap_pulse;
  logic [7:0]  wrap_cnt;
  logic [3:0]  lost_cnt;

  modport master (
    output data_valid, cnt, rd_en,
    input  fifo_dout, fifo_empty, fifo_full, wrap_pulse, wrap_cnt, lost_cnt
  );

  modport slave (
    input  data_valid, cnt, rd_en,
    output fifo_dout, fifo_empty, fifo_full, wrap_pulse, wrap_cnt, lost_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cnt_event_logger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnt_event_logger : START/STOP/WRAP event timestamper with FWFT FIFO  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cnt_event_logger #(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  cnt_event_logger_if.slave bus
);
  localparam int           AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]  CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]  CNT_ONE  = (AW+1)'(1);
  localparam logic [1:0]   T_START  = 2'b01;
  localparam logic [1:0]   T_STOP   = 2'b10;
  localparam logic [1:0]   T_WRAP   = 2'b11;

  logic [5:0]    cnt_q;
  logic          dv_q;
  logic [7:0]    ts;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   dout;
  logic          wrap_pulse_q;
  logic [7:0]    wrap_cnt_q;
  logic [3:0]    lost_q;

  logic          ev_start, ev_stop, ev_wrap, any_ev;
  logic [1:0]    ev_n, lost_inc;
  logic [4:0]    lost_sum;
  logic          empty, full, multi, rd_do, wr_do;
  logic [1:0]    rec_type;
  logic [15:0]   rec;
  logic [AW-1:0] rd_ptr_nx;

  always_comb begin
    ev_start  = bus.data_valid & ~dv_q;
    ev_stop   = ~bus.data_valid & dv_q;
    ev_wrap   = (cnt_q == 6'd63) && (bus.cnt == 6'd0);
    any_ev    = ev_start | ev_stop | ev_wrap;
    ev_n      = {1'b0, ev_start} + {1'b0, ev_stop} + {1'b0, ev_wrap};
    empty     = (count == '0);
    full      = (count == CNT_FULL);
    multi     = (count > CNT_ONE);
    rd_do     = bus.rd_en & ~empty;
    // A full FIFO still accepts a write when the same edge pops the head.
    wr_do     = any_ev & (~full | rd_do);
    lost_inc  = ev_n - {1'b0, wr_do};
    lost_sum  = {1'b0, lost_q} + {3'b000, lost_inc};
    rec_type  = T_START;
    if (ev_wrap)      rec_type = T_WRAP;
    else if (ev_stop) rec_type = T_STOP;
    rec       = {rec_type, bus.cnt, ts};
    rd_ptr_nx = rd_ptr + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst && wr_do) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      dv_q         <= 1'b0;
      ts           <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      dout         <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      lost_q       <= '0;
    end else begin
      cnt_q        <= bus.cnt;
      dv_q         <= bus.data_valid;
      ts           <= ts + 8'd1;
      wrap_pulse_q <= ev_wrap;
      wrap_cnt_q   <= wrap_cnt_q + {7'd0, ev_wrap};
      lost_q       <= (lost_sum > 5'd15) ? 4'd15 : lost_sum[3:0];
      if (wr_do) wr_ptr <= wr_ptr + AW'(1);
      if (rd_do) rd_ptr <= rd_ptr_nx;
      case ({wr_do, rd_do})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Head register: follows the next head, holds the last value once empty.
      if (empty && wr_do)      dout <= rec;
      else if (rd_do && multi) dout <= mem[rd_ptr_nx];
      else if (rd_do && wr_do) dout <= rec;
    end
  end

  assign bus.fifo_dout  = dout;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.wrap_cnt   = wrap_cnt_q;
  assign bus.lost_cnt   = lost_q;
endmodule
`default_nettype wire

// File: tb/tb_cnt_event_logger.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cnt_event_logger : scoreboard bench for cnt_event_logger          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cnt_event_logger;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  cnt_event_logger_if bus ();

  cnt_event_logger #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] q [$];
  logic [15:0] m_dout;
  logic        m_dvq;
  logic [5:0]  m_cntq;
  logic [7:0]  m_ts;
  logic [7:0]  m_wrap;
  int          m_lost;
  logic        cur_dv;

  // Drive one active cycle and advance the reference model alongside it.
  task automatic tick(input logic dv, input logic [5:0] c, input logic r);
    logic st, sp, wp, rd, wr;
    int   n;
    logic [15:0] rec;
    rst = 1'b1; bus.data_valid = dv; bus.cnt = c; bus.rd_en = r; cur_dv = dv;
    st  = dv && !m_dvq;
    sp  = !dv && m_dvq;
    wp  = (m_cntq == 6'd63) && (c == 6'd0);
    n   = int'(st) + int'(sp) + int'(wp);
    rd  = r && (q.size() > 0);
    wr  = (n > 0) && ((q.size() < DEPTH) || rd);
    rec = {(wp ? 2'b11 : (sp ? 2'b10 : 2'b01)), c, m_ts};
    @(posedge clk);
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(rec);
    m_lost = m_lost + n - int'(wr);
    if (m_lost > 15) m_lost = 15;
    m_wrap = m_wrap + {7'd0, wp};
    m_dvq  = dv;
    m_cntq = c;
    m_ts   = m_ts + 8'd1;
    if (q.size() > 0) m_dout = q[0];
    #1;
  endtask

  task automatic reset_tick(input logic dv, input logic [5:0] c, input logic r);
    rst = 1'b0; bus.data_valid = dv; bus.cnt = c; bus.rd_en = r; cur_dv = dv;
    @(posedge clk);
    q.delete();
    m_dout = '0; m_dvq = 1'b0; m_cntq = '0; m_ts = '0; m_wrap = '0; m_lost = 0;
    #1;
  endtask

  task automatic test_reset();
    reset_tick(1'($urandom), 6'($urandom), 1'($urandom));
    reset_tick(1'($urandom), 6'($urandom), 1'($urandom));
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.fifo_empty); end
    n_checks++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.fifo_full); end
    n_checks++; if (bus.fifo_dout !== 16'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0000", bus.fifo_dout); end
    n_checks++; if ({bus.wrap_pulse, bus.wrap_cnt, bus.lost_cnt} !== 13'd0) begin n_fail++; $display("FAIL reset_counters: got %b/%h/%h want 0", bus.wrap_pulse, bus.wrap_cnt, bus.lost_cnt); end
    for (int i = 0; i < 3; i++) tick(1'b0, 6'd0, 1'b0);
    tick(1'b1, 6'd0, 1'b0);
    n_checks++; if (bus.fifo_dout !== 16'h4003) begin n_fail++; $display("FAIL first_start: got %h want 4003", bus.fifo_dout); end
    n_checks++; if (bus.fifo_empty !== 1'b0) begin n_fail++; $display("FAIL first_start_empty: got %b want 0", bus.fifo_empty); end
    n_checks++; if (bus.fifo_dout !== q[0]) begin n_fail++; $display("FAIL sb_start: got %h want %h", bus.fifo_dout, q[0]); end
    tick(1'b1, 6'd0, 1'b1);
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL start_pop_empty: got %b want 1", bus.fifo_empty); end
  endtask

  task automatic test_stop();
    for (int i = 0; i < 300 && m_ts != 8'h20; i++) tick(1'b1, 6'd10, 1'b0);
    tick(1'b0, 6'd10, 1'b0);
    n_checks++; if (bus.fifo_dout !== 16'h8A20) begin n_fail++; $display("FAIL stop_record: got %h want 8a20", bus.fifo_dout); end
    n_checks++; if (bus.fifo_dout !== q[0]) begin n_fail++; $display("FAIL sb_stop: got %h want %h", bus.fifo_dout, q[0]); end
    tick(1'b0, 6'd10, 1'b1);
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL stop_pop_empty: got %b want 1", bus.fifo_empty); end
    n_checks++; if (bus.fifo_dout !== m_dout) begin n_fail++; $display("FAIL stop_hold: got %h want %h", bus.fifo_dout, m_dout); end
  endtask

  task automatic test_wrap();
    int pulses;
    tick(1'b1, 6'd62, 1'b0);
    n_checks++; if (bus.fifo_dout !== q[0]) begin n_fail++; $display("FAIL sb_wrap_start: got %h want %h", bus.fifo_dout, q[0]); end
    tick(1'b1, 6'd62, 1'b1);
    tick(1'b1, 6'd63, 1'b0);
    tick(1'b1, 6'd0, 1'b0);
    n_checks++; if (bus.fifo_dout[15:8] !== 8'hC0) begin n_fail++; $display("FAIL wrap_type_snap: got %h want c0", bus.fifo_dout[15:8]); end
    n_checks++; if (bus.fifo_dout !== q[0]) begin n_fail++; $display("FAIL sb_wrap: got %h want %h", bus.fifo_dout, q[0]); end
    n_checks++; if (bus.wrap_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_cnt_1: got %0d want 1", bus.wrap_cnt); end
    n_checks++; if (bus.wrap_pulse !== 1'b1) begin n_fail++; $display("FAIL wrap_pulse_hi: got %b want 1", bus.wrap_pulse); end
    tick(1'b1, 6'd0, 1'b1);
    n_checks++; if ({bus.wrap_pulse, bus.fifo_empty} !== 2'b01) begin n_fail++; $display("FAIL wrap_pulse_lo: got pulse %b empty %b want 0/1", bus.wrap_pulse, bus.fifo_empty); end
    pulses = 0;
    for (int i = 0; i < 255; i++) begin
      tick(1'b1, 6'd63, 1'b1);
      if (bus.wrap_pulse === 1'b1) pulses++;
      tick(1'b1, 6'd0, 1'b1);
      if (bus.wrap_pulse === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 255) begin n_fail++; $display("FAIL wrap_pulse_count: got %0d want 255", pulses); end
    tick(1'b1, 6'd0, 1'b1);
    n_checks++; if (bus.wrap_cnt !== 8'd0 || bus.wrap_cnt !== m_wrap) begin n_fail++; $display("FAIL wrap_cnt_roll: got %0d want 0", bus.wrap_cnt); end
    n_checks++; if (bus.lost_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_lost: got %0d want 0", bus.lost_cnt); end
  endtask

  task automatic test_full_lost();
    logic [15:0] last_rec;
    for (int i = 0; i < 5; i++) begin
      tick((i % 2) == 1, 6'd5, 1'b0);
      if (i == 2) begin
        n_checks++; if (bus.fifo_full !== 1'b0) begin n_fail++; $display("FAIL full_early: got %b want 0", bus.fifo_full); end
      end
      if (i == 3) begin
        n_checks++; if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_at_4: got %b want 1", bus.fifo_full); end
      end
    end
    n_checks++; if (bus.lost_cnt !== 4'd1) begin n_fail++; $display("FAIL lost_one: got %0d want 1", bus.lost_cnt); end
    last_rec = {2'b01, 6'd7, m_ts};
    tick(1'b1, 6'd7, 1'b1);
    n_checks++; if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_rw_occ: got %b want 1", bus.fifo_full); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (q.size() == 0 || bus.fifo_dout !== q[0]) begin n_fail++; $display("FAIL sb_full_%0d: got %h", k, bus.fifo_dout); end
      if (k == 3) begin
        n_checks++; if (bus.fifo_dout !== last_rec) begin n_fail++; $display("FAIL full_rw_last: got %h want %h", bus.fifo_dout, last_rec); end
      end
      tick(1'b1, 6'd7, 1'b1);
    end
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_drain_empty: got %b want 1", bus.fifo_empty); end
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 6'd63, 1'b0);
    tick(1'b0, 6'd0, 1'b0);
    n_checks++; if (bus.fifo_dout[15:14] !== 2'b11) begin n_fail++; $display("FAIL sim_type: got %b want 11", bus.fifo_dout[15:14]); end
    n_checks++; if (bus.lost_cnt !== 4'd2 || bus.lost_cnt !== 4'(m_lost)) begin n_fail++; $display("FAIL sim_lost: got %0d want 2", bus.lost_cnt); end
    n_checks++; if (bus.fifo_dout !== q[0] || q.size() != 1) begin n_fail++; $display("FAIL sb_sim: got %h want single record", bus.fifo_dout); end
    tick(1'b0, 6'd0, 1'b1);
    n_checks++; if (bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL sim_only_one: got empty %b want 1", bus.fifo_empty); end
    for (int i = 0; i < 24; i++) tick((i % 2) == 0, 6'd20, 1'b0);
    n_checks++; if (bus.lost_cnt !== 4'd15) begin n_fail++; $display("FAIL lost_saturate: got %0d want 15", bus.lost_cnt); end
    n_checks++; if (bus.fifo_full !== 1'b1) begin n_fail++; $display("FAIL sat_full: got %b want 1", bus.fifo_full); end
  endtask

  task automatic test_mid_reset();
    n_checks++; if (bus.fifo_dout !== q[0]) begin n_fail++; $display("FAIL sb_pre_reset: got %h want %h", bus.fifo_dout, q[0]); end
    tick(cur_dv, 6'd20, 1'b1);
    n_checks++; if ({bus.fifo_full, bus.fifo_empty} !== 2'b00) begin n_fail++; $display("FAIL three_queued: got full %b empty %b want 0/0", bus.fifo_full, bus.fifo_empty); end
    reset_tick(1'b1, 6'd0, 1'b0);
    n_checks++; if ({bus.fifo_empty, bus.fifo_full} !== 2'b10) begin n_fail++; $display("FAIL mid_rst_flags: got empty %b full %b want 1/0", bus.fifo_empty, bus.fifo_full); end
    n_checks++; if ({bus.wrap_cnt, bus.lost_cnt, bus.wrap_pulse} !== 13'd0) begin n_fail++; $display("FAIL mid_rst_counters: got %h/%h/%b want 0", bus.wrap_cnt, bus.lost_cnt, bus.wrap_pulse); end
    n_checks++; if (bus.fifo_dout !== 16'h0) begin n_fail++; $display("FAIL mid_rst_dout: got %h want 0000", bus.fifo_dout); end
    tick(1'b0, 6'd0, 1'b1);
    n_checks++; if (bus.fifo_dout !== 16'h0 || bus.fifo_empty !== 1'b1) begin n_fail++; $display("FAIL empty_read: got %h empty %b want 0000/1", bus.fifo_dout, bus.fifo_empty); end
  endtask

  initial begin
    bus.data_valid = 1'b0; bus.cnt = '0; bus.rd_en = 1'b0; cur_dv = 1'b0;
    m_dout = '0; m_dvq = 1'b0; m_cntq = '0; m_ts = '0; m_wrap = '0; m_lost = 0;
    @(negedge clk);
    test_reset();
    test_stop();
    test_wrap();
    test_full_lost();
    test_simultaneous();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
